// File: rtl/idu_queue.sv
// Instruction decode queue: decodes RV32/RV64 base instructions at enqueue and
// holds them in a small FIFO, blocking the head on a load-use hazard with EX.
module idu_queue #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_instr,
  input  logic [XLEN-1:0]          in_pc,
  input  logic                     flush,
  input  logic                     ex_load_valid,
  input  logic [4:0]               ex_load_rd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [31:0]              out_instr,
  output logic [2:0]               out_fmt,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [4:0]               out_rd,
  output logic                     out_uses_rs1,
  output logic                     out_uses_rs2,
  output logic [XLEN-1:0]          out_imm,
  output logic                     hazard_stall,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              illegal_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic [2:0]      fmt;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            uses_rs1;
    logic            uses_rs2;
    logic [XLEN-1:0] imm;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          dec_c;
  entry_t          head;
  logic [31:0]     imm32_c;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            enq;
  logic            deq;

  // Decode of the incoming instruction; immediates are built at 32 bits then sign-extended.
  always_comb begin
    dec_c       = '0;
    imm32_c     = '0;
    dec_c.pc    = in_pc;
    dec_c.instr = in_instr;
    case (in_instr[6:0])
      7'b0110011, 7'b0111011:                                  dec_c.fmt = FMT_R;
      7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011: dec_c.fmt = FMT_I;
      7'b0100011:                                              dec_c.fmt = FMT_S;
      7'b1100011:                                              dec_c.fmt = FMT_B;
      7'b0110111, 7'b0010111:                                  dec_c.fmt = FMT_U;
      7'b1101111:                                              dec_c.fmt = FMT_J;
      default:                                                 dec_c.fmt = FMT_ILL;
    endcase
    dec_c.uses_rs1 = (dec_c.fmt == FMT_R) || (dec_c.fmt == FMT_I) ||
                     (dec_c.fmt == FMT_S) || (dec_c.fmt == FMT_B);
    dec_c.uses_rs2 = (dec_c.fmt == FMT_R) || (dec_c.fmt == FMT_S) || (dec_c.fmt == FMT_B);
    dec_c.rs1 = dec_c.uses_rs1 ? in_instr[19:15] : 5'd0;
    dec_c.rs2 = dec_c.uses_rs2 ? in_instr[24:20] : 5'd0;
    if ((dec_c.fmt == FMT_R) || (dec_c.fmt == FMT_I) ||
        (dec_c.fmt == FMT_U) || (dec_c.fmt == FMT_J)) begin
      dec_c.rd = in_instr[11:7];
    end
    case (dec_c.fmt)
      FMT_I:   imm32_c = {{20{in_instr[31]}}, in_instr[31:20]};
      FMT_S:   imm32_c = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      FMT_B:   imm32_c = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
      FMT_U:   imm32_c = {in_instr[31:12], 12'b0};
      FMT_J:   imm32_c = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0};
      default: imm32_c = '0;
    endcase
    dec_c.imm = XLEN'($signed(imm32_c));
  end

  assign head = mem[rd_ptr];

  assign in_ready     = (count < CW'(DEPTH));
  assign hazard_stall = (count != '0) && ex_load_valid && (ex_load_rd != 5'd0) &&
                        ((head.uses_rs1 && (head.rs1 == ex_load_rd)) ||
                         (head.uses_rs2 && (head.rs2 == ex_load_rd)));
  assign out_valid    = (count != '0) && !hazard_stall;
  assign enq          = in_valid && in_ready && !flush;
  assign deq          = out_valid && out_ready && !flush;

  assign out_pc       = head.pc;
  assign out_instr    = head.instr;
  assign out_fmt      = head.fmt;
  assign out_rs1      = head.rs1;
  assign out_rs2      = head.rs2;
  assign out_rd       = head.rd;
  assign out_uses_rs1 = head.uses_rs1;
  assign out_uses_rs2 = head.uses_rs2;
  assign out_imm      = head.imm;

  // Payload storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= dec_c;
    end
  end

  // Occupancy, pointers and illegal counter; flush wins over enqueue/dequeue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      illegal_cnt <= '0;
    end else begin
      if (deq && (head.fmt == FMT_ILL) && (illegal_cnt != 16'hFFFF)) begin
        illegal_cnt <= illegal_cnt + 16'd1;
      end
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + PW'(1);
        if (deq) rd_ptr <= rd_ptr + PW'(1);
        case ({enq, deq})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_idu_queue.sv
// Bench for idu_queue: directed literal checks plus randomized traffic compared
// every cycle against a queue-based reference model (64- and 32-bit builds).
module tb_idu_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [63:0] in_pc;
  logic        flush;
  logic        ex_load_valid;
  logic [4:0]  ex_load_rd;
  logic        out_ready;

  logic        in_ready, out_valid, out_uses_rs1, out_uses_rs2, hazard_stall;
  logic [63:0] out_pc, out_imm;
  logic [31:0] out_instr;
  logic [2:0]  out_fmt;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [1:0]  count;
  logic [15:0] illegal_cnt;

  logic        in_ready32, out_valid32, out_uses_rs1_32, out_uses_rs2_32, hazard_stall32;
  logic [31:0] out_pc32, out_imm32, out_instr32;
  logic [2:0]  out_fmt32;
  logic [4:0]  out_rs1_32, out_rs2_32, out_rd32;
  logic [1:0]  count32;
  logic [15:0] illegal_cnt32;

  int n_cmp = 0;
  int n_err = 0;

  idu_queue #(.XLEN(64), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_fmt(out_fmt), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_rd(out_rd), .out_uses_rs1(out_uses_rs1),
    .out_uses_rs2(out_uses_rs2), .out_imm(out_imm),
    .hazard_stall(hazard_stall), .count(count), .illegal_cnt(illegal_cnt)
  );

  idu_queue #(.XLEN(32), .DEPTH(2)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .flush(flush),
    .ex_load_valid(ex_load_valid), .ex_load_rd(ex_load_rd),
    .out_valid(out_valid32), .out_ready(out_ready), .out_pc(out_pc32),
    .out_instr(out_instr32), .out_fmt(out_fmt32), .out_rs1(out_rs1_32),
    .out_rs2(out_rs2_32), .out_rd(out_rd32), .out_uses_rs1(out_uses_rs1_32),
    .out_uses_rs2(out_uses_rs2_32), .out_imm(out_imm32),
    .hazard_stall(hazard_stall32), .count(count32), .illegal_cnt(illegal_cnt32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          fmt;
    int          rs1;
    int          rs2;
    int          rd;
    bit          u1;
    bit          u2;
    logic [63:0] imm;
  } dec_t;

  // Reference decode: field table plus signed arithmetic on immediate pieces.
  function automatic dec_t model_dec(input logic [31:0] ins);
    dec_t   d;
    longint v;
    case (ins[6:0])
      7'h33, 7'h3B:                      d.fmt = 0;
      7'h03, 7'h13, 7'h1B, 7'h67, 7'h73: d.fmt = 1;
      7'h23:                             d.fmt = 2;
      7'h63:                             d.fmt = 3;
      7'h37, 7'h17:                      d.fmt = 4;
      7'h6F:                             d.fmt = 5;
      default:                           d.fmt = 7;
    endcase
    d.u1  = (d.fmt <= 3);
    d.u2  = (d.fmt == 0) || (d.fmt == 2) || (d.fmt == 3);
    d.rs1 = d.u1 ? int'(ins[19:15]) : 0;
    d.rs2 = d.u2 ? int'(ins[24:20]) : 0;
    d.rd  = (d.fmt == 0 || d.fmt == 1 || d.fmt == 4 || d.fmt == 5) ? int'(ins[11:7]) : 0;
    case (d.fmt)
      1: v = longint'(ins[30:20]) - (ins[31] ? longint'(2048) : 0);
      2: v = longint'(ins[30:25]) * 32 + longint'(ins[11:7]) - (ins[31] ? longint'(2048) : 0);
      3: v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2
             - (ins[31] ? longint'(4096) : 0);
      4: v = longint'(ins[30:12]) * 4096 - (ins[31] ? (longint'(1) << 31) : 0);
      5: v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2
             - (ins[31] ? (longint'(1) << 20) : 0);
      default: v = 0;
    endcase
    d.imm = 64'(v);
    return d;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model state: a plain queue of (instr, pc) plus the illegal counter.
  logic [31:0] mq_instr[$];
  logic [63:0] mq_pc[$];
  int          m_ill;

  function automatic bit model_haz();
    dec_t h;
    if (mq_instr.size() == 0 || !ex_load_valid || ex_load_rd == 5'd0) return 1'b0;
    h = model_dec(mq_instr[0]);
    return (h.u1 && h.rs1 == int'(ex_load_rd)) || (h.u2 && h.rs2 == int'(ex_load_rd));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq_instr.delete();
      mq_pc.delete();
      m_ill = 0;
    end else if (flush) begin
      mq_instr.delete();
      mq_pc.delete();
    end else begin
      bit do_enq;
      bit do_deq;
      do_enq = in_valid && (mq_instr.size() < 2);
      do_deq = (mq_instr.size() > 0) && !model_haz() && out_ready;
      if (do_deq) begin
        if (model_dec(mq_instr[0]).fmt == 7 && m_ill < 65535) m_ill++;
        void'(mq_instr.pop_front());
        void'(mq_pc.pop_front());
      end
      if (do_enq) begin
        mq_instr.push_back(in_instr);
        mq_pc.push_back(in_pc);
      end
    end
  end

  // Every-cycle comparison of both builds against the model.
  always @(negedge clk) begin
    int   n;
    bit   haz;
    dec_t h;
    if ($time > 2) begin
      n   = mq_instr.size();
      haz = model_haz();
      chk("count",       64'(count),        64'(n));
      chk("in_ready",    64'(in_ready),     64'(n < 2));
      chk("hazard",      64'(hazard_stall), 64'(haz));
      chk("out_valid",   64'(out_valid),    64'(n > 0 && !haz));
      chk("illegal_cnt", 64'(illegal_cnt),  64'(m_ill));
      chk("count32",     64'(count32),        64'(n));
      chk("in_ready32",  64'(in_ready32),     64'(n < 2));
      chk("hazard32",    64'(hazard_stall32), 64'(haz));
      chk("out_valid32", 64'(out_valid32),    64'(n > 0 && !haz));
      chk("illegal32",   64'(illegal_cnt32),  64'(m_ill));
      if (n > 0) begin
        h = model_dec(mq_instr[0]);
        chk("out_pc",    out_pc,              mq_pc[0]);
        chk("out_instr", 64'(out_instr),      64'(mq_instr[0]));
        chk("out_fmt",   64'(out_fmt),        64'(h.fmt));
        chk("out_rs1",   64'(out_rs1),        64'(h.rs1));
        chk("out_rs2",   64'(out_rs2),        64'(h.rs2));
        chk("out_rd",    64'(out_rd),         64'(h.rd));
        chk("uses_rs1",  64'(out_uses_rs1),   64'(h.u1));
        chk("uses_rs2",  64'(out_uses_rs2),   64'(h.u2));
        chk("out_imm",   out_imm,             h.imm);
        chk("out_pc32",    64'(out_pc32),    64'(mq_pc[0][31:0]));
        chk("out_instr32", 64'(out_instr32), 64'(mq_instr[0]));
        chk("out_fmt32",   64'(out_fmt32),   64'(h.fmt));
        chk("out_rs1_32",  64'(out_rs1_32),  64'(h.rs1));
        chk("out_rs2_32",  64'(out_rs2_32),  64'(h.rs2));
        chk("out_rd32",    64'(out_rd32),    64'(h.rd));
        chk("uses_rs1_32", 64'(out_uses_rs1_32), 64'(h.u1));
        chk("uses_rs2_32", 64'(out_uses_rs2_32), 64'(h.u2));
        chk("out_imm32",   64'(out_imm32),   64'(h.imm[31:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] opcodes [16];

  initial begin
    opcodes = '{7'h33, 7'h3B, 7'h03, 7'h13, 7'h1B, 7'h67, 7'h73, 7'h23,
                7'h63, 7'h37, 7'h17, 7'h6F, 7'h00, 7'h7F, 7'h0B, 7'h2F};
    rst = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
    ex_load_valid = 1'b0; ex_load_rd = '0; out_ready = 1'b0;
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_hazard",    64'(hazard_stall), 64'd0);
    tick();
    rst = 1'b0;

    // addi x1, x2, -1 at 0x80000000, visible one cycle after enqueue
    in_valid = 1'b1; in_instr = 32'hFFF10093; in_pc = 64'h8000_0000;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("d_valid", 64'(out_valid), 64'd1);
    chk("d_fmt",   64'(out_fmt),   64'd1);
    chk("d_rd",    64'(out_rd),    64'd1);
    chk("d_rs1",   64'(out_rs1),   64'd2);
    chk("d_urs2",  64'(out_uses_rs2), 64'd0);
    chk("d_imm",   out_imm,        64'hFFFF_FFFF_FFFF_FFFF);
    chk("d_pc",    out_pc,         64'h8000_0000);
    chk("d_imm32", 64'(out_imm32), 64'hFFFF_FFFF);

    // load-use hazard on rs1 = x2, then rd = x0 never stalls
    tick();
    ex_load_valid = 1'b1; ex_load_rd = 5'd2;
    @(negedge clk);
    chk("h_stall", 64'(hazard_stall), 64'd1);
    chk("h_valid", 64'(out_valid),    64'd0);
    tick();
    ex_load_rd = 5'd0;
    @(negedge clk);
    chk("h0_stall", 64'(hazard_stall), 64'd0);
    chk("h0_valid", 64'(out_valid),    64'd1);
    tick();
    ex_load_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("h_drain", 64'(count), 64'd0);

    // beq x0, x0, -4
    tick();
    in_valid = 1'b1; in_instr = 32'hFE000EE3; in_pc = 64'h8000_0004;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("b_fmt",   64'(out_fmt), 64'd3);
    chk("b_rs1",   64'(out_rs1), 64'd0);
    chk("b_rs2",   64'(out_rs2), 64'd0);
    chk("b_rd",    64'(out_rd),  64'd0);
    chk("b_imm",   out_imm,      64'hFFFF_FFFF_FFFF_FFFC);
    chk("b_imm32", 64'(out_imm32), 64'hFFFF_FFFC);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // fill to full with three offers, third refused, then one dequeue
    tick();
    in_valid = 1'b1; in_instr = 32'h0010_0093; in_pc = 64'h100;
    tick();
    in_instr = 32'h0020_0113; in_pc = 64'h104;
    @(negedge clk);
    chk("f_cnt1", 64'(count), 64'd1);
    tick();
    in_instr = 32'h0030_0193; in_pc = 64'h108;
    @(negedge clk);
    chk("f_cnt2",  64'(count),    64'd2);
    chk("f_ready", 64'(in_ready), 64'd0);
    tick();
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("f_cnt3", 64'(count), 64'd2);
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("f_cnt4",  64'(count),     64'd1);
    chk("f_head",  out_pc,         64'h104);
    chk("f_instr", 64'(out_instr), 64'h0020_0113);

    // flush of a full queue with an offer pending
    tick();
    in_valid = 1'b1; in_instr = 32'h0040_0213; in_pc = 64'h10C;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("fl_cnt",   64'(count),     64'd0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ready", 64'(in_ready),  64'd1);

    // all-zero word is illegal and bumps the counter when dequeued
    tick();
    in_valid = 1'b1; in_instr = 32'h0; in_pc = 64'h200;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("i_fmt", 64'(out_fmt), 64'd7);
    chk("i_imm", out_imm,      64'd0);
    chk("i_cnt0", 64'(illegal_cnt), 64'd0);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("i_cnt1", 64'(illegal_cnt), 64'd1);

    // randomized traffic with hazards, flushes and occasional reset
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] w;
      tick();
      w        = $urandom();
      w[6:0]   = opcodes[$urandom_range(0, 15)];
      if ($urandom_range(0, 1) == 0) w[19:15] = 5'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) w[24:20] = 5'($urandom_range(0, 3));
      in_instr      = w;
      in_pc         = {$urandom(), $urandom()};
      in_valid      = ($urandom_range(0, 3) != 0);
      out_ready     = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 15) == 0);
      ex_load_valid = ($urandom_range(0, 1) == 0);
      ex_load_rd    = 5'($urandom_range(0, 3));
      rst           = rst ? 1'b0 : ($urandom_range(0, 199) == 0);
    end

    // stream illegal words until the counter saturates
    tick();
    rst = 1'b1; flush = 1'b0; ex_load_valid = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();
    rst = 1'b0; in_valid = 1'b1; in_instr = 32'h0; in_pc = 64'h300; out_ready = 1'b1;
    repeat (65540) tick();
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("sat_cnt",   64'(illegal_cnt),   64'hFFFF);
    chk("sat_cnt32", 64'(illegal_cnt32), 64'hFFFF);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
